// File: rtl/key_sequencer_pkg.sv
// key_sequencer_pkg
// Shared definitions for the key-matrix write sequencer: injector FSM state
// encodings, PS/2 protocol byte constants and the Pause skip length.
package key_sequencer_pkg;

  // Injector FSM
  //   state    | meaning
  //   ST_IDLE  | waiting for injStrb, injBusy low
  //   ST_PRESS | press blocked by a live event, retry next cycle
  //   ST_HOLD  | key held, timer counts toward HOLD
  //   ST_REL   | release blocked by a live event, retry next cycle
  //   ST_GAP   | key released, timer counts toward GAP
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRESS = 3'd1,
    ST_HOLD  = 3'd2,
    ST_REL   = 3'd3,
    ST_GAP   = 3'd4
  } inj_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  // Bytes following 0xE1 that belong to the Pause make/break sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Controller chatter that never reaches the matrix and leaves prefix state alone.
  function automatic logic is_chatter(input logic [7:0] b);
    return (b == 8'h00) || (b == PS2_BAT) || (b == PS2_ACK) ||
           (b == PS2_RESEND) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/key_sequencer_decoder.sv
// scancode_decoder
// Turns the raw PS/2 byte stream into live key events. Strips 0xE0/0xF0
// prefixes, swallows the 8-byte Pause sequence and controller chatter.
// The live event is combinational from the incoming byte; the caller
// registers it.
//   clock      in   system clock
//   reset      in   synchronous active-high reset
//   byte_strb  in   one-cycle pulse, byte_data valid
//   byte_data  in   received PS/2 byte
//   live_valid out  a key event is present this cycle
//   live_make  out  0 = pressed, 1 = released
//   live_code  out  scancode with prefixes stripped
module scancode_decoder
  import key_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       byte_strb,
  input  logic [7:0] byte_data,
  output logic       live_valid,
  output logic       live_make,
  output logic [7:0] live_code
);

  // The E0 prefix needs no stored state: extended codes reach the matrix as
  // their base codes, so the prefix byte is simply consumed.
  logic       brk;
  logic [2:0] skip_cnt;
  logic       skipping;
  logic       is_prefix;

  assign skipping  = (skip_cnt != 3'd0);
  assign is_prefix = (byte_data == PS2_EXT) || (byte_data == PS2_BRK) ||
                     (byte_data == PS2_PAUSE);

  always_comb begin
    live_valid = byte_strb && !skipping && !is_prefix && !is_chatter(byte_data);
    live_make  = brk;
    live_code  = byte_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      brk      <= 1'b0;
      skip_cnt <= 3'd0;
    end else if (byte_strb) begin
      if (skipping) begin
        skip_cnt <= skip_cnt - 3'd1;
        if (skip_cnt == 3'd1) brk <= 1'b0;
      end else if (byte_data == PS2_PAUSE) begin
        skip_cnt <= PAUSE_SKIP;
      end else if (byte_data == PS2_BRK) begin
        brk <= 1'b1;
      end else if (byte_data == PS2_EXT) begin
        brk <= brk;
      end else if (!is_chatter(byte_data)) begin
        brk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/key_sequencer.sv
// key_sequencer
// Sole writer of the key-matrix latch. Merges live decoded PS/2 events with
// an auto-type injector that taps a code (press, hold, release, gap). Live
// events always own the output register; a blocked injector emission slips
// one cycle and the rest of its schedule slides with it.
//   clock    in   system clock
//   reset    in   synchronous active-high reset
//   rxStrb   in   one-cycle pulse, rxData valid
//   rxData   in   received PS/2 byte
//   injStrb  in   request to tap injCode, honoured only while injBusy=0
//   injCode  in   scancode to inject
//   injBusy  out  injector not idle
//   strb     out  one-cycle matrix write pulse
//   make     out  0 = pressed, 1 = released
//   code     out  scancode to write
module key_sequencer
  import key_sequencer_pkg::*;
#(
  parameter logic [23:0] HOLD = 24'd1000000,
  parameter logic [23:0] GAP  = 24'd1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxStrb,
  input  logic [7:0] rxData,
  input  logic       injStrb,
  input  logic [7:0] injCode,
  output logic       injBusy,
  output logic       strb,
  output logic       make,
  output logic [7:0] code
);

  localparam logic [23:0] HOLD_LAST = HOLD - 24'd1;
  localparam logic [23:0] GAP_LAST  = GAP - 24'd1;

  logic       live_valid;
  logic       live_make;
  logic [7:0] live_code;

  inj_state_t  state;
  logic [23:0] timer;
  logic [7:0]  inj_code;

  scancode_decoder u_decoder (
    .clock      (clock),
    .reset      (reset),
    .byte_strb  (rxStrb),
    .byte_data  (rxData),
    .live_valid (live_valid),
    .live_make  (live_make),
    .live_code  (live_code)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      timer    <= 24'd0;
      inj_code <= 8'h00;
      injBusy  <= 1'b0;
      strb     <= 1'b0;
      make     <= 1'b1;
      code     <= 8'h00;
    end else begin
      strb <= 1'b0;
      if (live_valid) begin
        strb <= 1'b1;
        make <= live_make;
        code <= live_code;
      end

      // Every injector emission below is gated on !live_valid, so it never
      // competes with the live write above.
      case (state)
        ST_IDLE: begin
          if (injStrb) begin
            inj_code <= injCode;
            injBusy  <= 1'b1;
            timer    <= 24'd0;
            if (!live_valid) begin
              strb  <= 1'b1;
              make  <= 1'b0;
              code  <= injCode;
              state <= ST_HOLD;
            end else begin
              state <= ST_PRESS;
            end
          end
        end
        ST_PRESS: begin
          if (!live_valid) begin
            strb  <= 1'b1;
            make  <= 1'b0;
            code  <= inj_code;
            timer <= 24'd0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // The release is emitted on the last HOLD cycle so that it lands
          // exactly HOLD cycles after the press; REL only covers the slip.
          if (timer == HOLD_LAST) begin
            timer <= 24'd0;
            if (!live_valid) begin
              strb  <= 1'b1;
              make  <= 1'b1;
              code  <= inj_code;
              state <= ST_GAP;
            end else begin
              state <= ST_REL;
            end
          end else begin
            timer <= timer + 24'd1;
          end
        end
        ST_REL: begin
          if (!live_valid) begin
            strb  <= 1'b1;
            make  <= 1'b1;
            code  <= inj_code;
            timer <= 24'd0;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer == GAP_LAST) begin
            timer   <= 24'd0;
            injBusy <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        default: begin
          timer   <= 24'd0;
          injBusy <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_sequencer.sv
module tb_key_sequencer;

  localparam int HOLD_C = 4;
  localparam int GAP_C  = 3;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       rxStrb  = 1'b0;
  logic [7:0] rxData  = 8'h00;
  logic       injStrb = 1'b0;
  logic [7:0] injCode = 8'h00;
  logic       injBusy;
  logic       strb;
  logic       make;
  logic [7:0] code;

  key_sequencer #(.HOLD(24'd4), .GAP(24'd3)) dut (
    .clock   (clock),
    .reset   (reset),
    .rxStrb  (rxStrb),
    .rxData  (rxData),
    .injStrb (injStrb),
    .injCode (injCode),
    .injBusy (injBusy),
    .strb    (strb),
    .make    (make),
    .code    (code)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       make;
    logic [7:0] code;
  } ev_t;

  ev_t got[$];
  ev_t exp_q[$];
  bit  busy_at[int];

  always @(negedge clock) begin
    ev_t e;
    busy_at[cyc] = injBusy;
    if (strb) begin
      e.cyc  = cyc;
      e.make = make;
      e.code = code;
      got.push_back(e);
    end
  end

  int tests  = 0;
  int failed = 0;

  // Reference decoder: counts of bytes left to skip and a pending-break flag.
  int m_skip    = 0;
  bit m_brk     = 0;
  bit use_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_ev(input int c, input logic mk, input logic [7:0] cd);
    ev_t e;
    e.cyc  = c;
    e.make = mk;
    e.code = cd;
    exp_q.push_back(e);
  endtask

  task automatic model_byte(input logic [7:0] b, input int t);
    if (m_skip > 0) begin
      m_skip--;
      if (m_skip == 0) m_brk = 0;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      // extended prefix: nothing visible to the matrix
    end else if (b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF}) begin
      // chatter
    end else begin
      expect_ev(t + 1, m_brk, b);
      m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    if (use_model) model_byte(b, cyc);
    rxStrb = 1'b1;
    rxData = b;
    tick();
    rxStrb = 1'b0;
  endtask

  task automatic inject(input logic [7:0] c, output int t);
    t       = cyc;
    injStrb = 1'b1;
    injCode = c;
    tick();
    injStrb = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    chk({tag, "_count"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_cyc"},  got[i].cyc,  exp_q[i].cyc);
      chk({tag, "_make"}, got[i].make, exp_q[i].make);
      chk({tag, "_code"}, got[i].code, exp_q[i].code);
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t2;
    logic [7:0] c, b;

    // Reset state
    idle(3);
    chk("rst_strb", strb, 1'b0);
    chk("rst_make", make, 1'b1);
    chk("rst_code", code, 8'h00);
    chk("rst_busy", injBusy, 1'b0);
    reset = 1'b0;
    idle(2);
    got.delete();

    // Make then break of 0x1C; F0 itself is silent
    t = cyc; send(8'h1C); expect_ev(t + 1, 1'b0, 8'h1C);
    idle(2);
    send(8'hF0);
    idle(2);
    t = cyc; send(8'h1C); expect_ev(t + 1, 1'b1, 8'h1C);
    idle(3);
    drain("make_break");

    // Extended make/break, then chatter
    send(8'hE0); t = cyc; send(8'h75); expect_ev(t + 1, 1'b0, 8'h75);
    idle(1);
    send(8'hE0); send(8'hF0); t = cyc; send(8'h75); expect_ev(t + 1, 1'b1, 8'h75);
    idle(1);
    send(8'hFA); idle(1); send(8'hAA);
    idle(3);
    drain("extended");

    // Pause sequence back to back, then 0x29
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    t = cyc; send(8'h29); expect_ev(t + 1, 1'b0, 8'h29);
    idle(3);
    drain("pause");

    // Injector with a request while busy, then a request on the first idle cycle
    inject(8'h5A, t);
    expect_ev(t + 1, 1'b0, 8'h5A);
    tick();
    injStrb = 1'b1; injCode = 8'h11; tick(); injStrb = 1'b0;
    expect_ev(t + 1 + HOLD_C, 1'b1, 8'h5A);
    idle_until(t + 8);
    inject(8'h3C, t2);
    chk("inj_back2back_t", t2, t + 8);
    expect_ev(t2 + 1, 1'b0, 8'h3C);
    expect_ev(t2 + 1 + HOLD_C, 1'b1, 8'h3C);
    idle_until(t2 + 12);
    drain("inject");
    chk("inj_busy_t0", busy_at[t], 1'b0);
    chk("inj_busy_t1", busy_at[t + 1], 1'b1);
    chk("inj_busy_t7", busy_at[t + 7], 1'b1);
    chk("inj_busy_t8", busy_at[t + 8], 1'b0);
    chk("inj2_busy_t1", busy_at[t2 + 1], 1'b1);
    chk("inj2_busy_t8", busy_at[t2 + 8], 1'b0);

    // Live event and injection in the same cycle: press slips
    t = cyc;
    rxStrb = 1'b1; rxData = 8'h16; injStrb = 1'b1; injCode = 8'h29;
    tick();
    rxStrb = 1'b0; injStrb = 1'b0;
    expect_ev(t + 1, 1'b0, 8'h16);
    expect_ev(t + 2, 1'b0, 8'h29);
    expect_ev(t + 6, 1'b1, 8'h29);
    idle_until(t + 12);
    drain("press_slip");
    chk("press_slip_busy8", busy_at[t + 8], 1'b1);
    chk("press_slip_busy9", busy_at[t + 9], 1'b0);

    // Live event on the release cycle: release slips
    inject(8'h44, t);
    expect_ev(t + 1, 1'b0, 8'h44);
    idle_until(t + 4);
    send(8'h33);
    expect_ev(t + 5, 1'b0, 8'h33);
    expect_ev(t + 6, 1'b1, 8'h44);
    idle_until(t + 12);
    drain("rel_slip");
    chk("rel_slip_busy8", busy_at[t + 8], 1'b1);
    chk("rel_slip_busy9", busy_at[t + 9], 1'b0);

    // Reset during HOLD with a pending break prefix
    send(8'hF0);
    idle(1);
    inject(8'h66, t);
    expect_ev(t + 1, 1'b0, 8'h66);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_strb", strb, 1'b0);
    chk("midrst_make", make, 1'b1);
    chk("midrst_code", code, 8'h00);
    chk("midrst_busy", injBusy, 1'b0);
    idle_until(t + 12);
    drain("midrst");
    t = cyc; send(8'h1C); expect_ev(t + 1, 1'b0, 8'h1C);
    idle(1);
    inject(8'h77, t2);
    expect_ev(t2 + 1, 1'b0, 8'h77);
    expect_ev(t2 + 1 + HOLD_C, 1'b1, 8'h77);
    idle_until(t2 + 11);
    drain("after_rst");
    chk("after_rst_busy7", busy_at[t2 + 7], 1'b1);
    chk("after_rst_busy8", busy_at[t2 + 8], 1'b0);

    // Random byte stream against the reference decoder
    m_skip = 0; m_brk = 0; use_model = 1;
    repeat (80) begin
      case ($urandom_range(0, 9))
        0: b = 8'hF0;
        1: b = 8'hE0;
        2: b = ($urandom_range(0, 2) == 0) ? 8'hE1 : 8'h12;
        3: case ($urandom_range(0, 4))
             0: b = 8'h00;
             1: b = 8'hAA;
             2: b = 8'hFA;
             3: b = 8'hFE;
             default: b = 8'hFF;
           endcase
        default: b = 8'($urandom_range(0, 255));
      endcase
      send(b);
      idle($urandom_range(0, 2));
    end
    idle(3);
    drain("rand_dec");

    // Random taps with live traffic during HOLD and ignored busy requests
    repeat (6) begin
      c = 8'($urandom_range(0, 255));
      inject(c, t);
      expect_ev(t + 1, 1'b0, c);
      tick();
      if ($urandom_range(0, 1) == 1) send(8'($urandom_range(0, 255)));
      else tick();
      injStrb = 1'b1; injCode = ~c; tick(); injStrb = 1'b0;
      expect_ev(t + 1 + HOLD_C, 1'b1, c);
      idle_until(t + 1 + HOLD_C + GAP_C + 1 + $urandom_range(0, 2));
      chk("rand_busy7", busy_at[t + HOLD_C + GAP_C], 1'b1);
      chk("rand_busy8", busy_at[t + 1 + HOLD_C + GAP_C], 1'b0);
    end
    idle(2);
    drain("rand_inj");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/key_sequencer.md
# key_sequencer

Sequences all writes into the Spectrum key-matrix latch. Decodes the raw PS/2 byte stream (make/break/extended prefixes, Pause sequence, controller chatter) into single-cycle `strb`/`make`/`code` events. Arbitrates those live events against an auto-type injector that taps a code (press, hold, release, gap), so the firmware or loader can type into the machine. Sits between the PS/2 receiver and the key-matrix block; its three outputs drive that block's `strb`, `make` and `code` inputs directly.

## Interface
- `HOLD`, default 24'd1000000: cycles between injected press strobe and release strobe; legal range 1..2^24-1.
- `GAP`, default 24'd1000000: cycles between injected release strobe and `injBusy` falling; legal range 1..2^24-1.
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `rxStrb`  in  1  one-cycle pulse: `rxData` holds a received PS/2 byte.
- `rxData`  in  8  received PS/2 byte.
- `injStrb`  in  1  one-cycle request to tap `injCode`; accepted only while `injBusy`=0.
- `injCode`  in  8  scancode to inject, sampled with `injStrb`.
- `injBusy`  out  1  injector not idle.
- `strb`  out  1  one-cycle matrix-write pulse.
- `make`  out  1  matrix level for `code`: 0 = pressed, 1 = released (matrix is active-low).
- `code`  out  8  scancode with prefixes stripped.

## Operation
- Decoder flags: `brk` set by 0xF0, `ext` set by 0xE0; both cleared after the next non-prefix byte.
- 0xE1 loads the skip counter with 7. The next 7 bytes are discarded without events (Pause). All flags are cleared when the count expires.
- Bytes 0x00, 0xAA, 0xFA, 0xFE and 0xFF are discarded. Flags are unchanged.
- Any other byte produces a live event: `code`=byte, `make`=`brk`. `ext` is dropped. The matrix sees E0-prefixed codes such as 0x75 up and 0x14 as their unprefixed codes.
- Injector FSM states:
  - IDLE: on `injStrb`, latch `injCode`. Emit the press (`make`=0) this cycle if no live event, then go to HOLD. Otherwise go to PRESS.
  - PRESS: emit the press when no live event, then go to HOLD.
  - HOLD: count to HOLD, then go to REL.
  - REL: emit the release (`make`=1) when no live event, then go to GAP.
  - GAP: count to GAP, then go to IDLE.
- `injBusy` is high in every state except IDLE. `injStrb` while busy is ignored, not queued.
- Priority: a live event always wins the output register. A blocked injector emission slips by one cycle, and the remaining schedule shifts with it. Live events are never dropped: the PS/2 byte rate is far below the clock rate, so at most one conflict exists per injector emission.
- Counters are 24-bit, load 0 on state entry, and compare equality with `HOLD-1` and `GAP-1`. They never wrap.
- Live events touching the injected code during HOLD pass through unchanged. The last writer wins in the matrix.

## Timing
- Output register updates on `clock`. Reset values: `strb`=0, `make`=1, `code`=8'h00, `injBusy`=0, FSM=IDLE, `brk`=`ext`=0, skip count=0, counters=0.
- Live latency: `rxStrb` in cycle t gives `strb` in t+1.
- Injector, no conflicts:
  - `injStrb` at t gives the press strobe at t+1 and `injBusy`=1 from t+1.
  - The release strobe comes HOLD cycles after the press strobe.
  - `injBusy` falls GAP cycles after the release strobe.
  - A new `injStrb` is accepted in the cycle `injBusy` reads 0.
- Simultaneous `rxStrb` and `injStrb` at t: live event at t+1, injected press at t+2.
- `strb` is never high in two consecutive cycles for the same emission source. Back-to-back live and injected strobes are allowed.
- Reset mid-operation: the FSM returns to IDLE and no release is emitted. A key held in the matrix stays held; clearing the matrix is the matrix owner's job. Partial prefixes and the Pause skip are abandoned.

## Structure
- Shared package holds:
  - FSM state encodings (IDLE, PRESS, HOLD, REL, GAP).
  - Byte constants PS2_EXT=0xE0, PS2_BRK=0xF0, PS2_PAUSE=0xE1, PS2_BAT=0xAA, PS2_ACK=0xFA, PS2_RESEND=0xFE.
  - Constant PAUSE_SKIP=7.
- One sub-module, `scancode_decoder`: byte in, prefix and skip state, one-cycle live-event valid/make/code out. The injector FSM, counters and output arbitration stay in `key_sequencer`.

## Test plan
- Bytes 0x1C, then 0xF0 0x1C → `strb` at t+1 with `make`=0 `code`=0x1C, then one `strb` with `make`=1 `code`=0x1C; no strobe for 0xF0.
- Bytes 0xE0 0x75, 0xE0 0xF0 0x75, then 0xFA and 0xAA → make and break events for code 0x75 only; no events for 0xFA or 0xAA.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 0x29 → no events for the 8 Pause bytes; one make event for 0x29.
- HOLD=4, GAP=3, `injStrb` with `injCode`=0x5A at t → press strobe at t+1, release strobe at t+5, `injBusy` 1 from t+1 and 0 at t+8; `injStrb` at t+2 is ignored.
- HOLD=4, GAP=3, `rxStrb`=0x16 and `injStrb`=0x29 both at t → live event 0x16 at t+1, press 0x29 at t+2, release at t+6.
- `reset` asserted during HOLD → next cycle `strb`=0, `make`=1, `code`=0, `injBusy`=0; no release strobe follows; the next `injStrb` runs the full sequence.
